ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter for the mouse interface. It sends one command byte, such as 0xF4 (enable data reporting) or 0xFF (reset), from the FPGA host to the mouse. It runs the full host-initiated sequence: clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop bit and device acknowledge. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables, and sits beside the receive path in the mouse top level.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds PS/2 clock low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, maximum clk cycles from clock release to the end of WAIT_RELEASE before the transfer is aborted.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
tx_start  in  1  request to send tx_data; accepted only when busy=0
tx_data  in  8  command byte; latched on accept
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
ps2_data_in  in  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_data_oe  out  1  1 = pull PS/2 data low
busy  out  1  transfer in progress
tx_done  out  1  1-cycle pulse: byte acknowledged by device
tx_error  out  1  1-cycle pulse: no ack or timeout

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, FSM in IDLE, counters 0. Both lines are released on the next edge, including mid-frame.
- Line conditioning:
  - Each input goes through a 2-FF synchronizer, then an 8-bit shift filter.
  - Filtered level goes to 1 only when all 8 samples are 1, and to 0 only when all 8 are 0; otherwise it holds.
  - fall_tick is a 1-cycle pulse on a filtered clock 1->0 transition.
  - Filtered data is sampled at fall_tick.
- IDLE: busy=0, both oe=0. When tx_start=1, latch tx_data, compute odd parity (parity bit = ~^data), clear the edge counter, go to INHIBIT. busy=1 from the next cycle.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. On the last cycle set data_oe=1 (start bit), then go to RTS.
- RTS: clk_oe=0 and data_oe stays 1. Start the timeout counter. Go to SHIFT.
- SHIFT: on each fall_tick, increment the edge counter n and drive the line for edge n:
  - edge 1..8: data_oe = ~data[n-1]
  - edge 9: data_oe = ~parity
  - edge 10: data_oe = 0 (stop bit, line released)
  - After edge 10, go to ACK.
- ACK: at the next fall_tick (edge 11), sample filtered data.
  - 0 = ack: go to WAIT_RELEASE.
  - 1 = no ack: pulse tx_error, go to IDLE.
- WAIT_RELEASE: wait until filtered clock=1 and filtered data=1, then pulse tx_done and go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in RTS, SHIFT, ACK or WAIT_RELEASE, release both lines, pulse tx_error and go to IDLE. Timeout has priority over a fall_tick in the same cycle.
- tx_start while busy=1 is ignored; tx_data is not relatched.
- busy returns to 0 in the same cycle tx_done or tx_error is asserted. A new tx_start is accepted the following cycle.
- tx_done and tx_error are never asserted together.
- Filter latency: 2 (sync) + 8 (filter) clk cycles after a raw edge. The device low/high phase must exceed 10 clk cycles.

Test Plan:
1. INHIBIT_CYCLES=20, device model with 40-cycle PS/2 clock, send 0xF4 -> clk_oe high exactly 20 cycles; data bits sampled on device rising edges = 0,0,1,0,1,1,1,1; parity 0; stop 1; ack low -> one tx_done pulse, busy falls, tx_error stays 0.
2. Send 0xFF, device does not pull data low at edge 11 -> bits all 1, parity 1, then one tx_error pulse, no tx_done, both oe=0.
3. TIMEOUT_CYCLES=2000, device never clocks after RTS -> data_oe=1 held, then tx_error exactly 2000 cycles after clk_oe release, lines released.
4. Pulse tx_start with tx_data=0x00 during a 0xF4 transfer -> ignored; frame bits remain those of 0xF4 and only one tx_done occurs.
5. Assert rst=0 for 1 cycle at edge 5 of a frame -> next cycle both oe=0, busy=0, no done/error pulse; a fresh tx_start of 0xF3 then completes normally.
6. Inject 3-cycle glitches on ps2_clk_in during SHIFT -> no extra fall_tick; frame content unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send,
// 8 data bits LSB first, odd parity, stop bit, then device acknowledge.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,    // must be >= 2
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_RELEASE
  } state_t;

  logic [1:0]       r_clk_sync, r_data_sync;
  logic [7:0]       r_clk_sh, r_data_sh;
  logic             r_clk_f, r_data_f, r_clk_f_d;
  logic             w_fall;

  state_t           r_state;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [3:0]       r_edge_cnt;
  logic [7:0]       r_data;
  logic             r_parity;

  // Synchronise and glitch-filter both lines; filters idle at the released (high) level
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_sh    <= 8'hFF;
      r_data_sh   <= 8'hFF;
      r_clk_f     <= 1'b1;
      r_data_f    <= 1'b1;
      r_clk_f_d   <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
      r_data_sync <= {r_data_sync[0], ps2_data_in};
      r_clk_sh    <= {r_clk_sh[6:0], r_clk_sync[1]};
      r_data_sh   <= {r_data_sh[6:0], r_data_sync[1]};
      if (&r_clk_sh)        r_clk_f <= 1'b1;
      else if (~|r_clk_sh)  r_clk_f <= 1'b0;
      if (&r_data_sh)       r_data_f <= 1'b1;
      else if (~|r_data_sh) r_data_f <= 1'b0;
      r_clk_f_d   <= r_clk_f;
    end
  end

  assign w_fall = r_clk_f_d & ~r_clk_f;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_inh_cnt   <= '0;
      r_to_cnt    <= '0;
      r_edge_cnt  <= '0;
      r_data      <= '0;
      r_parity    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          if (tx_start) begin
            r_data     <= tx_data;
            r_parity   <= ~^tx_data;
            r_edge_cnt <= '0;
            r_inh_cnt  <= '0;
            ps2_clk_oe <= 1'b1;
            busy       <= 1'b1;
            r_state    <= S_INHIBIT;
          end
        end
        // Start bit goes low one cycle before the clock is released
        S_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + INH_W'(1);
          if (r_inh_cnt == INH_START) ps2_data_oe <= 1'b1;
          if (r_inh_cnt == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            r_to_cnt   <= '0;
            r_state    <= S_RTS;
          end
        end
        default: begin
          if (r_to_cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_error    <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            case (r_state)
              S_RTS: r_state <= S_SHIFT;
              S_SHIFT: begin
                if (w_fall) begin
                  r_edge_cnt <= r_edge_cnt + 4'd1;
                  if (r_edge_cnt < 4'd8) begin
                    ps2_data_oe <= ~r_data[r_edge_cnt[2:0]];
                  end else if (r_edge_cnt == 4'd8) begin
                    ps2_data_oe <= ~r_parity;
                  end else begin
                    ps2_data_oe <= 1'b0;
                    r_state     <= S_ACK;
                  end
                end
              end
              S_ACK: begin
                if (w_fall) begin
                  if (r_data_f) begin
                    busy     <= 1'b0;
                    tx_error <= 1'b1;
                    r_state  <= S_IDLE;
                  end else begin
                    r_state <= S_WAIT_RELEASE;
                  end
                end
              end
              S_WAIT_RELEASE: begin
                if (r_clk_f && r_data_f) begin
                  busy    <= 1'b0;
                  tx_done <= 1'b1;
                  r_state <= S_IDLE;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-drain lines, vector
// table of frames with a scoreboard, plus timeout and mid-frame reset sequences.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TO  = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         glitch;
    bit         ignore_start;
    logic       parity;
    int         exp_done;
    int         exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    bit         has_frame;
    int         done;
    int         err;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, oe_run = 0, last_oe_run = 0, dev_falls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse counting, end-of-transfer invariants, clock-inhibit length
  always @(negedge clk) begin
    if (rst) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done || tx_error) begin
        check("busy_low_at_end", 32'(busy), 32'd0);
        check("done_err_exclusive", 32'(tx_done & tx_error), 32'd0);
      end
    end
    if (ps2_clk_oe) oe_run++;
    else if (oe_run != 0) begin
      last_oe_run = oe_run;
      oe_run = 0;
    end
  end

  // Device: wait for request-to-send, then clock npulses (20 low / 20 high)
  task automatic dev_frame(input int npulses, input bit ack, input bit glitch,
                           output logic [9:0] bits, output bit ok);
    int t;
    ok = 1'b0;
    bits = '0;
    t = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      t++;
      if (!ps2_clk_oe && ps2_data_oe) ok = 1'b1;
    end
    if (ok) begin
      repeat (20) @(negedge clk);
      for (int p = 1; p <= npulses; p++) begin
        dev_clk_low = 1'b1;
        dev_falls++;
        repeat (20) @(negedge clk);
        if (p <= 10) bits[p-1] = ps2_data_in;
        dev_clk_low = 1'b0;
        if (p == 11) dev_data_low = 1'b0;
        for (int c = 0; c < 20; c++) begin
          if (glitch && p <= 10 && c == 12) dev_clk_low = 1'b1;
          if (glitch && p <= 10 && c == 15) dev_clk_low = 1'b0;
          if (ack && p == 10 && c == 5) dev_data_low = 1'b1;
          @(negedge clk);
        end
      end
    end
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] d);
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic compare_result(input logic [9:0] bits, input int d0, input int e0);
    exp_t got;
    check("sb_not_empty", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      got = sb_q.pop_front();
      if (got.has_frame) begin
        check("frame_data", 32'(bits[7:0]), 32'(got.data));
        check("frame_parity", 32'(bits[8]), 32'(got.parity));
        check("frame_stop", 32'(bits[9]), 32'd1);
      end
      check("done_pulses", 32'(done_cnt - d0), 32'(got.done));
      check("error_pulses", 32'(err_cnt - e0), 32'(got.err));
    end
    check("lines_idle", {29'd0, ps2_clk_oe, ps2_data_oe, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    logic [9:0] bits;
    bit ok;
    int d0, e0, t;
    e.data = v.data; e.parity = v.parity; e.has_frame = 1'b1;
    e.done = v.exp_done; e.err = v.exp_err;
    sb_q.push_back(e);
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(v.data);
    fork
      dev_frame(11, v.ack, v.glitch, bits, ok);
      if (v.ignore_start) begin
        repeat (150) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    check("rts_seen", 32'(ok), 32'd1);
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
    check("inhibit_len", 32'(last_oe_run), 32'(INH));
    compare_result(bits, d0, e0);
  endtask

  vec_t vecs[6];

  initial begin
    int d0, e0, t, cyc;
    bit held_bad, ok;
    logic [9:0] bits;
    exp_t e;

    vecs[0] = '{8'hF4, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};
    vecs[2] = '{8'hF4, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};

    rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error}, 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Device silent after request-to-send: error exactly TO cycles after clock release
    e.data = 8'h5A; e.parity = 1'b1; e.has_frame = 1'b0; e.done = 0; e.err = 1;
    sb_q.push_back(e);
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h5A);
    t = 0;
    while (ps2_clk_oe && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("clk_released", 32'(ps2_clk_oe), 32'd0);
    cyc = 0; held_bad = 1'b0;
    while (!tx_error && cyc < 2500) begin
      if (!ps2_data_oe) held_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 32'(TO));
    check("start_bit_held", 32'(held_bad), 32'd0);
    check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (20) @(negedge clk);
    compare_result(10'd0, d0, e0);

    // Reset during the fifth clock of a frame
    d0 = done_cnt; e0 = err_cnt;
    t = dev_falls;
    start_tx(8'hF4);
    fork
      dev_frame(5, 1'b0, 1'b0, bits, ok);
      begin
        cyc = 0;
        while (dev_falls < t + 5 && cyc < 1000) begin
          @(negedge clk);
          cyc++;
        end
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("reset_midframe", {29'd0, ps2_clk_oe, ps2_data_oe, busy}, 32'd0);
      end
    join
    repeat (100) @(negedge clk);
    check("rst_frame_low_bits", 32'(bits[3:0]), 32'h4);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_no_error", 32'(err_cnt - e0), 32'd0);
    check("rst_idle", {29'd0, ps2_clk_oe, ps2_data_oe, busy}, 32'd0);
    run_vec('{8'hF3, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
